gemm_tile_sequencer: RTL and testbench

- Sequences one output-stationary GEMM tile through the systolic array: clears accumulators, streams k_len skewed operand beats, flushes the skew pipeline, then reads result rows out under a valid/ready handshake.
- Sits between the tile-issue logic (start/done) and the array datapath (shift enable, zero-feed, accumulator clear, row readout).

---
 rtl/gemm_tile_sequencer.sv | 164 ++++++++++++++++
 tb/tb_gemm_tile_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_sequencer.sv
// Tile sequencer for an output-stationary systolic GEMM array: clear, stream, flush, readout.
// Optional performance counters are enabled with the GEMM_SEQ_PERF_CNT_EN macro.
module gemm_tile_sequencer #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int K_MAX = 16
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [$clog2(K_MAX):0]                   k_len,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     err,
    output logic                                     acc_clear,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    output logic                                     shift_en,
    output logic                                     feed_zero,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row_idx
`ifdef GEMM_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                              perf_stall_cycles,
    output logic [31:0]                              perf_bp_cycles
`endif
);
    localparam int KW        = $clog2(K_MAX) + 1;
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FLUSH_LEN = ROWS + COLS - 2;
    localparam int FW        = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    localparam logic [KW-1:0] K_MAX_V    = KW'(K_MAX);
    localparam logic [FW-1:0] FLUSH_LAST = FW'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_STREAM  = 3'd2;
    localparam logic [2:0] S_FLUSH   = 3'd3;
    localparam logic [2:0] S_READOUT = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]    state_reg, state_next;
    logic [KW-1:0] k_len_reg, k_len_next;
    logic [KW-1:0] beat_reg, beat_next, beat_inc;
    logic [FW-1:0] flush_reg, flush_next;
    logic [RW-1:0] row_reg, row_next;
    logic          err_reg, err_next;
    logic          k_len_ok;

    assign k_len_ok = (k_len != '0) && (k_len <= K_MAX_V);
    assign beat_inc = beat_reg + KW'(1);

    always_comb begin
        state_next = state_reg;
        k_len_next = k_len_reg;
        beat_next  = beat_reg;
        flush_next = flush_reg;
        row_next   = row_reg;
        err_next   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (k_len_ok) begin
                        k_len_next = k_len;
                        state_next = S_CLEAR;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                beat_next  = '0;
                flush_next = '0;
                row_next   = '0;
                state_next = S_STREAM;
            end
            S_STREAM: begin
                // in_ready is constant here, so a beat is simply in_valid
                if (in_valid) begin
                    beat_next = beat_inc;
                    if (beat_inc == k_len_reg) begin
                        state_next = (FLUSH_LEN == 0) ? S_READOUT : S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_reg == FLUSH_LAST) begin
                    state_next = S_READOUT;
                end else begin
                    flush_next = flush_reg + FW'(1);
                end
            end
            S_READOUT: begin
                if (out_ready) begin
                    if (row_reg == ROW_LAST) begin
                        row_next   = '0;
                        state_next = S_DONE;
                    end else begin
                        row_next = row_reg + RW'(1);
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            k_len_reg <= '0;
            beat_reg  <= '0;
            flush_reg <= '0;
            row_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_len_reg <= k_len_next;
            beat_reg  <= beat_next;
            flush_reg <= flush_next;
            row_reg   <= row_next;
            err_reg   <= err_next;
        end
    end

    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_DONE);
    assign err         = err_reg;
    assign acc_clear   = (state_reg == S_CLEAR);
    assign in_ready    = (state_reg == S_STREAM);
    assign shift_en    = ((state_reg == S_STREAM) && in_valid) || (state_reg == S_FLUSH);
    assign feed_zero   = (state_reg == S_FLUSH);
    assign out_valid   = (state_reg == S_READOUT);
    assign out_row_idx = row_reg;

`ifdef GEMM_SEQ_PERF_CNT_EN
    // index 0: operand starvation in STREAM, index 1: consumer backpressure in READOUT
    logic [1:0] perf_evt;
    assign perf_evt[0] = (state_reg == S_STREAM) && !in_valid;
    assign perf_evt[1] = (state_reg == S_READOUT) && !out_ready;

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        logic [31:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (reset || (state_reg == S_CLEAR)) begin
                cnt_reg <= '0;
            end else if (perf_evt[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = g_perf[0].cnt_reg;
    assign perf_bp_cycles    = g_perf[1].cnt_reg;
`endif

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Self-checking bench for gemm_tile_sequencer; expected per-cycle traces come from a schedule model.
module tb_gemm_tile_sequencer;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int K_MAX = 16;
    localparam int KW    = $clog2(K_MAX) + 1;
    localparam int RW    = 2;
    localparam int NC    = 96;

    logic clk = 1'b0;
    logic reset, start, in_valid, out_ready;
    logic [KW-1:0] k_len;
    logic busy, done, err, acc_clear, in_ready, shift_en, feed_zero, out_valid;
    logic [RW-1:0] out_row_idx;
`ifdef GEMM_SEQ_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_bp_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bit         valid_pat [NC];
    bit         ready_pat [NC];
    logic [9:0] exp_tr [NC];
    logic [9:0] obs_tr [NC];
    int         exp_done, run_len, exp_stall, exp_bp;

    always #5 clk = ~clk;

    gemm_tile_sequencer #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .k_len      (k_len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .acc_clear  (acc_clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .shift_en   (shift_en),
        .feed_zero  (feed_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row_idx(out_row_idx)
`ifdef GEMM_SEQ_PERF_CNT_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_bp_cycles   (perf_bp_cycles)
`endif
    );

    // Output vector: {busy,done,err,acc_clear,in_ready,shift_en,feed_zero,out_valid,out_row_idx}
    function automatic logic [9:0] cur_outputs();
        return {busy, done, err, acc_clear, in_ready, shift_en, feed_zero, out_valid, out_row_idx};
    endfunction

    function automatic logic [9:0] mk(input bit b, input bit d, input bit e, input bit a,
                                      input bit ir, input bit se, input bit fz, input bit ov,
                                      input int idx);
        return {b, d, e, a, ir, se, fz, ov, RW'(idx)};
    endfunction

    task automatic set_patterns(input int pct_valid_low, input int pct_ready_low);
        for (int i = 0; i < NC; i++) begin
            valid_pat[i] = (i >= 40) || ($urandom_range(99) >= pct_valid_low);
            ready_pat[i] = (i >= 40) || ($urandom_range(99) >= pct_ready_low);
        end
    endtask

    // Schedule model: walk the tile phase by phase over the input patterns.
    task automatic build_expected(input int k, input bit hold);
        int c, beats, row;
        for (int i = 0; i < NC; i++) exp_tr[i] = '0;
        exp_stall = 0;
        exp_bp    = 0;
        exp_tr[1] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0);
        c = 2;
        beats = 0;
        while (beats < k && c < NC - 16) begin
            exp_tr[c] = mk(1, 0, 0, 0, 1, valid_pat[c], 0, 0, 0);
            if (valid_pat[c]) beats++;
            else exp_stall++;
            c++;
        end
        for (int f = 0; f < ROWS + COLS - 2; f++) begin
            exp_tr[c] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);
            c++;
        end
        row = 0;
        while (row < ROWS && c < NC - 4) begin
            exp_tr[c] = mk(1, 0, 0, 0, 0, 0, 0, 1, row);
            if (ready_pat[c]) row++;
            else exp_bp++;
            c++;
        end
        exp_done  = c;
        exp_tr[c] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
        if (hold) exp_tr[c + 2] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0);
        run_len = c + 3;
    endtask

    task automatic run_tile(input int k, input bit hold);
        build_expected(k, hold);
        for (int c = 0; c < run_len; c++) begin
            start     = (c == 0) || hold;
            k_len     = KW'(k);
            in_valid  = valid_pat[c];
            out_ready = ready_pat[c];
            @(negedge clk);
            obs_tr[c] = cur_outputs();
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        $display("tile k=%0d hold=%0d model done cycle %0d stalls %0d bp %0d",
                 k, hold, exp_done, exp_stall, exp_bp);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; k_len = KW'(3); in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (cur_outputs() !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %b required %b", i, cur_outputs(), 10'd0);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0; reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef GEMM_SEQ_PERF_CNT_EN
        n_checks++;
        if (perf_stall_cycles !== 32'd0 || perf_bp_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_perf: got %0d/%0d required 0/0", perf_stall_cycles, perf_bp_cycles);
        end
`endif
    endtask

    task automatic test_nominal();
        for (int i = 0; i < NC; i++) begin valid_pat[i] = 1'b1; ready_pat[i] = 1'b1; end
        run_tile(3, 1'b0);
        for (int c = 0; c < run_len; c++) begin
            n_checks++;
            if (obs_tr[c] !== exp_tr[c]) begin
                n_fail++;
                $display("FAIL nominal cycle %0d: got %b required %b", c, obs_tr[c], exp_tr[c]);
            end
        end
        n_checks++;
        if (obs_tr[15] !== mk(1, 1, 0, 0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL nominal_done15: got %b required done at cycle 15", obs_tr[15]);
        end
    endtask

    task automatic test_input_stall();
        for (int i = 0; i < NC; i++) begin valid_pat[i] = (i < 2 || i > 4); ready_pat[i] = 1'b1; end
        run_tile(2, 1'b0);
        for (int c = 0; c < run_len; c++) begin
            n_checks++;
            if (obs_tr[c] !== exp_tr[c]) begin
                n_fail++;
                $display("FAIL input_stall cycle %0d: got %b required %b", c, obs_tr[c], exp_tr[c]);
            end
        end
        n_checks++;
        if (obs_tr[17][8] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done17: got done=%b required 1", obs_tr[17][8]);
        end
`ifdef GEMM_SEQ_PERF_CNT_EN
        n_checks++;
        if (perf_stall_cycles !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_stall: got %0d required 3", perf_stall_cycles);
        end
`endif
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < NC; i++) begin valid_pat[i] = 1'b1; ready_pat[i] = (i != 12 && i != 13); end
        run_tile(3, 1'b0);
        for (int c = 0; c < run_len; c++) begin
            n_checks++;
            if (obs_tr[c] !== exp_tr[c]) begin
                n_fail++;
                $display("FAIL backpressure cycle %0d: got %b required %b", c, obs_tr[c], exp_tr[c]);
            end
        end
`ifdef GEMM_SEQ_PERF_CNT_EN
        n_checks++;
        if (perf_bp_cycles !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_bp: got %0d required 2", perf_bp_cycles);
        end
`endif
    endtask

    task automatic test_rejects();
        logic [9:0] exp_v;
        for (int c = 0; c < 4; c++) begin
            start = (c < 2); k_len = (c == 0) ? KW'(0) : KW'(17); in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            exp_v = (c == 1 || c == 2) ? mk(0, 0, 1, 0, 0, 0, 0, 0, 0) : 10'd0;
            n_checks++;
            if (cur_outputs() !== exp_v) begin
                n_fail++;
                $display("FAIL reject cycle %0d: got %b required %b", c, cur_outputs(), exp_v);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        for (int i = 0; i < NC; i++) begin valid_pat[i] = 1'b1; ready_pat[i] = 1'b1; end
        run_tile(16, 1'b0);
        for (int c = 0; c < run_len; c++) begin
            n_checks++;
            if (obs_tr[c] !== exp_tr[c]) begin
                n_fail++;
                $display("FAIL kmax_tile cycle %0d: got %b required %b", c, obs_tr[c], exp_tr[c]);
            end
        end
    endtask

    task automatic test_reset_mid_tile();
        int done_seen;
        for (int c = 0; c < 8; c++) begin
            start = (c == 0); k_len = KW'(3); in_valid = 1'b1; out_ready = 1'b1; reset = (c == 6);
            @(negedge clk);
            if (c == 6) begin
                n_checks++;
                if (feed_zero !== 1'b1) begin
                    n_fail++;
                    $display("FAIL midreset_in_flush: got feed_zero=%b required 1", feed_zero);
                end
            end
            if (c == 7) begin
                n_checks++;
                if (cur_outputs() !== 10'd0) begin
                    n_fail++;
                    $display("FAIL midreset_outputs: got %b required %b", cur_outputs(), 10'd0);
                end
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0; start = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy !== 1'b0) done_seen++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got %0d busy/done cycles required 0", done_seen);
        end
        for (int i = 0; i < NC; i++) begin valid_pat[i] = 1'b1; ready_pat[i] = 1'b1; end
        run_tile(1, 1'b0);
        for (int c = 0; c < run_len; c++) begin
            n_checks++;
            if (obs_tr[c] !== exp_tr[c]) begin
                n_fail++;
                $display("FAIL after_reset_tile cycle %0d: got %b required %b", c, obs_tr[c], exp_tr[c]);
            end
        end
        n_checks++;
        if (obs_tr[13][8] !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_done13: got done=%b required 1", obs_tr[13][8]);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        k = $urandom_range(K_MAX, 1);
        set_patterns(30, 30);
        run_tile(k, 1'b1);
        for (int c = 0; c < run_len; c++) begin
            n_checks++;
            if (obs_tr[c] !== exp_tr[c]) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %b required %b", c, obs_tr[c], exp_tr[c]);
            end
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_random();
        int k;
        for (int t = 0; t < 6; t++) begin
            k = $urandom_range(K_MAX, 1);
            set_patterns($urandom_range(60), $urandom_range(60));
            run_tile(k, 1'b0);
            for (int c = 0; c < run_len; c++) begin
                n_checks++;
                if (obs_tr[c] !== exp_tr[c]) begin
                    n_fail++;
                    $display("FAIL random%0d cycle %0d: got %b required %b", t, c, obs_tr[c], exp_tr[c]);
                end
            end
`ifdef GEMM_SEQ_PERF_CNT_EN
            n_checks++;
            if (perf_stall_cycles !== 32'(exp_stall) || perf_bp_cycles !== 32'(exp_bp)) begin
                n_fail++;
                $display("FAIL random%0d_perf: got %0d/%0d required %0d/%0d",
                         t, perf_stall_cycles, perf_bp_cycles, exp_stall, exp_bp);
            end
`endif
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
        test_reset();
        test_nominal();
        test_input_stall();
        test_backpressure();
        test_rejects();
        test_reset_mid_tile();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
